gpu_text_engine: RTL

GPU_TEXT_ENGINE -- requirements
Module: gpu_text_engine

---
 rtl/gpu_pkg.sv | 30 +++
 rtl/gpu_vram_arbiter.sv | 37 +++
 rtl/gpu_text_engine.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gpu_pkg.sv
// Shared definitions for the text engine: FSM state encoding, text grid size,
// register offsets within the engine's I/O window and CTRL bit positions.
package gpu_pkg;

    localparam int COLS      = 80;
    localparam int ROWS      = 30;
    localparam int VRAM_SIZE = COLS * ROWS;

    // Register offsets from the engine I/O base address
    localparam logic [7:0] REG_CTRL_OFS = 8'd0;
    localparam logic [7:0] REG_FILL_OFS = 8'd1;

    // CTRL write bit positions
    localparam int CTRL_SCROLL_BIT = 0;
    localparam int CTRL_FILL_BIT   = 1;
    localparam int CTRL_IE_BIT     = 2;
    localparam int CTRL_FLAG_BIT   = 3;

    localparam logic [7:0] FILL_CHAR_RESET = 8'h20;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_SC_RD  = 3'd1,
        ST_SC_CAP = 3'd2,
        ST_SC_WR  = 3'd3,
        ST_FILL   = 3'd4,
        ST_DONE   = 3'd5
    } gpu_state_e;

endpackage

// File: rtl/gpu_vram_arbiter.sv
// Fixed-priority mux for the single VRAM port: a CPU write always wins,
// otherwise the engine request passes through.
// Ports:
//   cpu_req/cpu_addr/cpu_wdata   : in-range CPU write request (already decoded)
//   eng_we/eng_re/eng_addr/...   : engine request for this cycle
//   eng_grant                    : 1 when the engine's request reached the port
//   vram_addr/wdata/we/re        : shared VRAM port
module gpu_vram_arbiter (
    input  logic        cpu_req,
    input  logic [11:0] cpu_addr,
    input  logic [7:0]  cpu_wdata,
    input  logic        eng_we,
    input  logic        eng_re,
    input  logic [11:0] eng_addr,
    input  logic [7:0]  eng_wdata,
    output logic        eng_grant,
    output logic [11:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    output logic        vram_re
);

    always_comb begin
        eng_grant  = ~cpu_req;
        vram_addr  = eng_addr;
        vram_wdata = eng_wdata;
        vram_we    = eng_we;
        vram_re    = eng_re;
        if (cpu_req) begin
            vram_addr  = cpu_addr;
            vram_wdata = cpu_wdata;
            vram_we    = 1'b1;
            vram_re    = 1'b0;
        end
    end

endmodule

// File: rtl/gpu_text_engine.sv
// Text-mode VRAM engine: scrolls the grid up one row (bottom row cleared with
// the FILL character) or fills the whole grid, sharing one VRAM port with CPU
// memory writes, which always take priority.
// Ports:
//   clk, rst                       : clock, synchronous active-high reset
//   din, address, w_en, r_en       : CPU data/address and I/O strobes
//   vram_w_en_cpu                  : CPU memory write strobe toward VRAM
//   dout                           : registered I/O read data (0 when not reading)
//   vram_addr/wdata/we/re, rdata   : shared VRAM port (rdata valid 1 cycle after re)
//   engine_done_interrupt_flag(_clr): completion flag and its clear
//
// Handshake: the engine presents one request per cycle and only advances a
// port-using state when eng_grant is high; otherwise it re-presents the same
// request next cycle. SC_CAP uses no port cycle and always advances.
module gpu_text_engine #(
    parameter logic [7:0]  GPU_ENGINE_IO_ADDRESS = 8'h01,
    parameter logic [15:0] GPU_VRAM_ADDRESS      = 16'h2000,
    parameter int          COLS                  = gpu_pkg::COLS,
    parameter int          ROWS                  = gpu_pkg::ROWS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  din,
    input  logic [15:0] address,
    input  logic        w_en,
    input  logic        r_en,
    input  logic        vram_w_en_cpu,
    output logic [7:0]  dout,
    output logic [11:0] vram_addr,
    output logic [7:0]  vram_wdata,
    output logic        vram_we,
    output logic        vram_re,
    input  logic [7:0]  vram_rdata,
    output logic        engine_done_interrupt_flag,
    input  logic        engine_done_interrupt_flag_clr
);

    localparam int          VRAM_SIZE   = COLS * ROWS;
    localparam logic [11:0] COLS_12     = 12'(COLS);
    localparam logic [11:0] LAST_IDX    = 12'(VRAM_SIZE - 1);
    localparam logic [11:0] SCROLL_LAST = 12'(VRAM_SIZE - COLS - 1);
    localparam logic [15:0] VRAM_SIZE_16 = 16'(VRAM_SIZE);

    import gpu_pkg::*;

    localparam logic [15:0] CTRL_ADDR = 16'(GPU_ENGINE_IO_ADDRESS) + 16'(REG_CTRL_OFS);
    localparam logic [15:0] FILL_ADDR = 16'(GPU_ENGINE_IO_ADDRESS) + 16'(REG_FILL_OFS);

    gpu_state_e  state_q, state_d;
    logic [11:0] idx_q, idx_d;
    logic [7:0]  cap_q, cap_d;
    logic [7:0]  fill_q, fill_d;
    logic [7:0]  dout_q, dout_d;
    logic        op_q, op_d;        // 1 = fill, 0 = scroll
    logic        ie_q, ie_d;
    logic        fv_q, fv_d;        // last written flag value
    logic        flag_q, flag_d;

    logic        ctrl_wr, fill_wr, ctrl_rd, fill_rd;
    logic        busy;
    logic        done_set;
    logic [15:0] cpu_off;
    logic        cpu_req;
    logic        eng_we, eng_re, eng_grant;
    logic [11:0] eng_addr;
    logic [7:0]  eng_wdata;

    // CPU write window; the subtraction wraps below the base, hence both tests
    assign cpu_off = address - GPU_VRAM_ADDRESS;
    assign cpu_req = vram_w_en_cpu && (address >= GPU_VRAM_ADDRESS) && (cpu_off < VRAM_SIZE_16);

    assign ctrl_wr = w_en && (address == CTRL_ADDR);
    assign fill_wr = w_en && (address == FILL_ADDR);
    assign ctrl_rd = r_en && (address == CTRL_ADDR);
    assign fill_rd = r_en && (address == FILL_ADDR);
    assign busy    = (state_q != ST_IDLE);

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cap_d     = cap_q;
        fill_d    = fill_q;
        op_d      = op_q;
        ie_d      = ie_q;
        fv_d      = fv_q;
        flag_d    = flag_q;
        dout_d    = 8'h00;
        done_set  = 1'b0;
        eng_we    = 1'b0;
        eng_re    = 1'b0;
        eng_addr  = idx_q;
        eng_wdata = fill_q;

        if (ctrl_wr) begin
            ie_d = din[CTRL_IE_BIT];
            fv_d = din[CTRL_FLAG_BIT];
        end
        if (fill_wr) begin
            fill_d = din;
        end

        case (state_q)
            ST_IDLE: begin
                // fill has priority when both start bits are written
                if (ctrl_wr && din[CTRL_FILL_BIT]) begin
                    state_d = ST_FILL;
                    idx_d   = 12'd0;
                    op_d    = 1'b1;
                end else if (ctrl_wr && din[CTRL_SCROLL_BIT]) begin
                    state_d = ST_SC_RD;
                    idx_d   = 12'd0;
                    op_d    = 1'b0;
                end
            end
            ST_SC_RD: begin
                eng_re   = 1'b1;
                eng_addr = idx_q + COLS_12;
                if (eng_grant) state_d = ST_SC_CAP;
            end
            ST_SC_CAP: begin
                // read was issued last cycle, so data is valid regardless of ownership
                cap_d   = vram_rdata;
                state_d = ST_SC_WR;
            end
            ST_SC_WR: begin
                eng_we    = 1'b1;
                eng_wdata = cap_q;
                if (eng_grant) begin
                    if (idx_q == SCROLL_LAST) begin
                        idx_d   = SCROLL_LAST + 12'd1;
                        state_d = ST_FILL;
                    end else begin
                        idx_d   = idx_q + 12'd1;
                        state_d = ST_SC_RD;
                    end
                end
            end
            ST_FILL: begin
                eng_we = 1'b1;
                if (eng_grant) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = ST_DONE;
                    end else begin
                        idx_d = idx_q + 12'd1;
                    end
                end
            end
            ST_DONE: begin
                done_set = ie_q;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (engine_done_interrupt_flag_clr) begin
            flag_d = 1'b0;
        end else if (ctrl_wr) begin
            flag_d = din[CTRL_FLAG_BIT];
        end else if (done_set) begin
            flag_d = 1'b1;
        end

        if (ctrl_rd) begin
            dout_d = {busy, 3'b000, op_q, fv_q, ie_q, flag_q};
        end else if (fill_rd) begin
            dout_d = fill_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= 12'd0;
            cap_q   <= 8'h00;
            fill_q  <= FILL_CHAR_RESET;
            dout_q  <= 8'h00;
            op_q    <= 1'b0;
            ie_q    <= 1'b0;
            fv_q    <= 1'b0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cap_q   <= cap_d;
            fill_q  <= fill_d;
            dout_q  <= dout_d;
            op_q    <= op_d;
            ie_q    <= ie_d;
            fv_q    <= fv_d;
            flag_q  <= flag_d;
        end
    end

    gpu_vram_arbiter u_arb (
        .cpu_req   (cpu_req),
        .cpu_addr  (cpu_off[11:0]),
        .cpu_wdata (din),
        .eng_we    (eng_we),
        .eng_re    (eng_re),
        .eng_addr  (eng_addr),
        .eng_wdata (eng_wdata),
        .eng_grant (eng_grant),
        .vram_addr (vram_addr),
        .vram_wdata(vram_wdata),
        .vram_we   (vram_we),
        .vram_re   (vram_re)
    );

    assign dout                       = dout_q;
    assign engine_done_interrupt_flag = flag_q;

endmodule
